// File: rtl/fir_mac_scheduler.sv
// Shared-MAC FIR for CHANNELS streams; grant -> out_valid seen FILTER_LENGTH+3 edges later, req_ready low while busy.
// Define FIR_SAT_EN to clip out-of-range results (out_sat=1); otherwise results wrap to IW bits.
module fir_mac_scheduler #(
    parameter int IW             = 16,
    parameter int FILTER_LENGTH  = 20,
    parameter int CHANNELS       = 2,
    localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [IW*FILTER_LENGTH-1:0]   coefficients_i,
    input  logic [CHANNELS-1:0]           req_valid_i,
    input  logic [IW*CHANNELS-1:0]        req_data_i,
    output logic [CHANNELS-1:0]           req_ready_o,
    input  logic                          flush_i,
    output logic                          busy_o,
    output logic                          out_valid_o,
    output logic [CW-1:0]                 out_chan_o,
    output logic signed [IW-1:0]          out_data_o,
    output logic                          out_sat_o
);

    localparam int TW = $clog2(FILTER_LENGTH);
    localparam int AW = 2 * IW + TW;
    localparam logic signed [AW-1:0] RND_HALF = AW'(64'sd1 << (IW - 2));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_RND,
        S_OUT,
        S_FLUSH
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          rr_q;
    logic [CW-1:0]          chan_q;
    logic signed [IW-1:0]   smp_q;
    logic [TW-1:0]          tap_q;
    logic [TW-1:0]          rp_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [IW-1:0]   hist_q [CHANNELS][FILTER_LENGTH];
    logic [TW-1:0]          wp_q [CHANNELS];
    logic                   out_valid_q;
    logic [CW-1:0]          out_chan_q;
    logic signed [IW-1:0]   out_data_q;
    logic                   out_sat_q;

    logic signed [IW-1:0]   coef_a [FILTER_LENGTH];
    logic signed [IW-1:0]   data_a [CHANNELS];
    logic [CW-1:0]          gnt_chan_d;
    logic [CW-1:0]          rr_d;
    logic [CW-1:0]          arb_idx;
    logic                   gnt_any;
    logic signed [2*IW-1:0] prod_d;
    logic signed [AW-1:0]   acc_d;
    logic signed [IW-1:0]   out_data_d;
    logic                   out_sat_d;

    always_comb begin
        for (int k = 0; k < FILTER_LENGTH; k++) begin
            coef_a[k] = coefficients_i[k*IW +: IW];
        end
        for (int c = 0; c < CHANNELS; c++) begin
            data_a[c] = req_data_i[c*IW +: IW];
        end
    end

    // First valid channel at or after the round-robin pointer; flush wins over any request.
    always_comb begin
        req_ready_o = '0;
        gnt_chan_d  = rr_q;
        gnt_any     = 1'b0;
        arb_idx     = '0;
        if (state_q == S_IDLE && !reset_i && !flush_i) begin
            for (int i = 0; i < CHANNELS; i++) begin
                arb_idx = CW'((int'(rr_q) + i) % CHANNELS);
                if (!gnt_any && req_valid_i[arb_idx]) begin
                    gnt_any                  = 1'b1;
                    gnt_chan_d               = arb_idx;
                    req_ready_o[arb_idx]     = 1'b1;
                end
            end
        end
        rr_d = (gnt_chan_d == CW'(CHANNELS - 1)) ? '0 : gnt_chan_d + 1'b1;
    end

    always_comb begin
        prod_d = hist_q[chan_q][rp_q] * coef_a[tap_q];
        acc_d  = acc_q + $signed({{TW{prod_d[2*IW-1]}}, prod_d});
    end

`ifdef FIR_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 << (IW - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(64'sd1 << (IW - 1)));
    logic signed [AW-1:0] r_d;

    always_comb begin
        r_d = (acc_q + RND_HALF) >>> (IW - 1);
        if (r_d > SAT_MAX) begin
            out_data_d = {1'b0, {(IW-1){1'b1}}};
            out_sat_d  = 1'b1;
        end else if (r_d < SAT_MIN) begin
            out_data_d = {1'b1, {(IW-1){1'b0}}};
            out_sat_d  = 1'b1;
        end else begin
            out_data_d = IW'(r_d);
            out_sat_d  = 1'b0;
        end
    end
`else
    always_comb begin
        out_data_d = IW'((acc_q + RND_HALF) >>> (IW - 1));
        out_sat_d  = 1'b0;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            chan_q      <= '0;
            smp_q       <= '0;
            tap_q       <= '0;
            rp_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                wp_q[c] <= '0;
                for (int k = 0; k < FILTER_LENGTH; k++) begin
                    hist_q[c][k] <= '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (flush_i) begin
                        state_q <= S_FLUSH;
                        tap_q   <= '0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            wp_q[c] <= '0;
                        end
                    end else if (gnt_any) begin
                        state_q <= S_LOAD;
                        chan_q  <= gnt_chan_d;
                        smp_q   <= data_a[gnt_chan_d];
                        rr_q    <= rr_d;
                    end
                end
                S_LOAD: begin
                    hist_q[chan_q][wp_q[chan_q]] <= smp_q;
                    acc_q   <= '0;
                    tap_q   <= '0;
                    rp_q    <= wp_q[chan_q];
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    tap_q <= tap_q + 1'b1;
                    rp_q  <= (rp_q == '0) ? TW'(FILTER_LENGTH - 1) : rp_q - 1'b1;
                    // The write pointer only moves once the sample is fully consumed.
                    if (tap_q == TW'(FILTER_LENGTH - 1)) begin
                        wp_q[chan_q] <= (wp_q[chan_q] == TW'(FILTER_LENGTH - 1)) ? '0
                                        : wp_q[chan_q] + 1'b1;
                        state_q      <= S_RND;
                    end
                end
                S_RND: begin
                    out_valid_q <= 1'b1;
                    out_chan_q  <= chan_q;
                    out_data_q  <= out_data_d;
                    out_sat_q   <= out_sat_d;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                S_FLUSH: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        hist_q[c][tap_q] <= '0;
                    end
                    tap_q <= tap_q + 1'b1;
                    if (tap_q == TW'(FILTER_LENGTH - 1)) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign out_valid_o = out_valid_q;
    assign out_chan_o  = out_chan_q;
    assign out_data_o  = out_data_q;
    assign out_sat_o   = out_sat_q;

endmodule
